// File: rtl/etc_tile_writer_if.sv
// Handshake bundle for etc_tile_writer: tile start, pixel input, row output.
interface etc_tile_writer_if;
    logic         blk_start;
    logic [9:0]   blk_x;
    logic [9:0]   blk_y;
    logic [9:0]   img_w_blk;
    logic         pix_valid;
    logic [3:0]   pix_idx;
    logic [7:0]   r;
    logic [7:0]   g;
    logic [7:0]   b;
    logic [7:0]   a;
    logic         pix_rtr;
    logic         row_valid;
    logic         row_ready;
    logic [127:0] row_data;
    logic [23:0]  row_addr;
    logic         blk_done;

    modport master (
        output blk_start, blk_x, blk_y, img_w_blk,
        output pix_valid, pix_idx, r, g, b, a,
        output row_ready,
        input  pix_rtr, row_valid, row_data, row_addr, blk_done
    );

    modport slave (
        input  blk_start, blk_x, blk_y, img_w_blk,
        input  pix_valid, pix_idx, r, g, b, a,
        input  row_ready,
        output pix_rtr, row_valid, row_data, row_addr, blk_done
    );
endinterface

// File: rtl/etc_tile_writer.sv
// Collects a 4x4 ETC tile in any order and emits it as 4 raster rows.
// Define ETC_TILE_WRITER_ALPHA_EN to store alpha; otherwise alpha is 8'hFF.
module etc_tile_writer (
    input logic              sclk,
    input logic              rsrt,
    etc_tile_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [1:0]  row_q, row_d;
    logic [9:0]  bx_q, bx_d;
    logic [9:0]  by_q, by_d;
    logic [9:0]  w_q, w_d;
    logic        done_q, done_d;

    logic [7:0]  r_mem [16];
    logic [7:0]  g_mem [16];
    logic [7:0]  b_mem [16];
`ifdef ETC_TILE_WRITER_ALPHA_EN
    logic [7:0]  a_mem [16];
`endif

    logic        pix_acc;
    logic        emit;
    logic [23:0] ypix, wpix, addr;
    logic [127:0] data;

    assign emit    = (state_q == EMIT);
    assign pix_acc = (state_q == COLLECT) && bus.pix_valid;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        row_d   = row_q;
        bx_d    = bx_q;
        by_d    = by_q;
        w_d     = w_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.blk_start) begin
                    bx_d    = bus.blk_x;
                    by_d    = bus.blk_y;
                    w_d     = bus.img_w_blk;
                    mask_d  = '0;
                    row_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.pix_valid) begin
                    mask_d = mask_q | (16'h1 << bus.pix_idx);
                    if (&mask_d) state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.row_ready) begin
                    row_d = row_q + 2'd1;
                    if (row_q == 2'd3) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            state_q <= IDLE;
            mask_q  <= '0;
            row_q   <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            w_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            row_q   <= row_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            w_q     <= w_d;
            done_q  <= done_d;
        end
    end

    // Pixel storage is overwritten for every tile, so it carries no reset.
    always_ff @(posedge sclk) begin
        if (pix_acc) begin
            r_mem[bus.pix_idx] <= bus.r;
            g_mem[bus.pix_idx] <= bus.g;
            b_mem[bus.pix_idx] <= bus.b;
`ifdef ETC_TILE_WRITER_ALPHA_EN
            a_mem[bus.pix_idx] <= bus.a;
`endif
        end
    end

    // Slot index is column-major: {x, y}, with y = current row.
    always_comb begin
        data = '0;
        if (emit) begin
            for (int x = 0; x < 4; x++) begin
`ifdef ETC_TILE_WRITER_ALPHA_EN
                data[32*x+24 +: 8] = a_mem[{2'(x), row_q}];
`else
                data[32*x+24 +: 8] = 8'hFF;
`endif
                data[32*x+16 +: 8] = b_mem[{2'(x), row_q}];
                data[32*x+8  +: 8] = g_mem[{2'(x), row_q}];
                data[32*x    +: 8] = r_mem[{2'(x), row_q}];
            end
        end
    end

    assign ypix = 24'({by_q, 2'b00}) + 24'(row_q);
    assign wpix = 24'({w_q, 2'b00});
    assign addr = ypix * wpix + 24'({bx_q, 2'b00});

    assign bus.pix_rtr   = (state_q == COLLECT);
    assign bus.row_valid = emit;
    assign bus.row_data  = data;
    assign bus.row_addr  = emit ? addr : 24'd0;
    assign bus.blk_done  = done_q;
endmodule

// File: tb/tb_etc_tile_writer.sv
// Scoreboard bench for etc_tile_writer: ordering, backpressure, ignores, reset.
module tb_etc_tile_writer;
    logic sclk = 1'b0;
    logic rsrt;
    etc_tile_writer_if bus();

    etc_tile_writer dut (.sclk(sclk), .rsrt(rsrt), .bus(bus));

    always #5 sclk = ~sclk;

    typedef struct {
        logic [127:0] data;
        logic [23:0]  addr;
    } row_t;

    row_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    logic [7:0]   mr [16], mg [16], mb [16], ma [16];
    int           cur_bx, cur_by, cur_w;
    logic         stall_prev = 1'b0;
    logic [127:0] prev_data;
    logic [23:0]  prev_addr;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_alpha(input logic [7:0] a);
`ifdef ETC_TILE_WRITER_ALPHA_EN
        return a;
`else
        return 8'hFF;
`endif
    endfunction

    task automatic start_tile(input int bx, input int by, input int w);
        bus.blk_start = 1'b1;
        bus.blk_x     = 10'(bx);
        bus.blk_y     = 10'(by);
        bus.img_w_blk = 10'(w);
        cur_bx = bx; cur_by = by; cur_w = w;
        @(posedge sclk); #1;
        bus.blk_start = 1'b0;
        check("rtr_collect", 128'(bus.pix_rtr), 128'(1));
    endtask

    task automatic send_pix(input int idx, input logic [7:0] r);
        logic [7:0] g, b, a;
        g = 8'($urandom);
        b = 8'($urandom);
        a = 8'($urandom);
        bus.pix_valid = 1'b1;
        bus.pix_idx   = 4'(idx);
        bus.r = r; bus.g = g; bus.b = b; bus.a = a;
        mr[idx] = r; mg[idx] = g; mb[idx] = b; ma[idx] = a;
        @(posedge sclk); #1;
        bus.pix_valid = 1'b0;
    endtask

    task automatic push_rows();
        row_t e;
        int   ad;
        for (int y = 0; y < 4; y++) begin
            e.data = '0;
            for (int x = 0; x < 4; x++)
                e.data[32*x +: 32] = {exp_alpha(ma[x*4+y]), mb[x*4+y],
                                      mg[x*4+y], mr[x*4+y]};
            ad = (cur_by*4 + y) * (cur_w*4) + cur_bx*4;
            e.addr = ad[23:0];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 40 && done_cnt < target; i++) @(posedge sclk);
        #1;
        check("blk_done_cnt", 128'(done_cnt), 128'(target));
    endtask

    always @(negedge sclk) begin
        row_t e;
        if (rsrt && bus.blk_done) done_cnt++;
        if (rsrt && bus.row_valid) begin
            check("rtr_in_emit", 128'(bus.pix_rtr), 128'(0));
            if (stall_prev) begin
                check("hold_data", bus.row_data, prev_data);
                check("hold_addr", 128'(bus.row_addr), 128'(prev_addr));
            end
            if (bus.row_ready) begin
                if (exp_q.size() == 0) begin
                    check("row_unexpected", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("row_data", bus.row_data, e.data);
                    check("row_addr", 128'(bus.row_addr), 128'(e.addr));
                end
            end
            stall_prev = !bus.row_ready;
            prev_data  = bus.row_data;
            prev_addr  = bus.row_addr;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        rsrt = 1'b0;
        bus.blk_start = 0; bus.blk_x = 0; bus.blk_y = 0; bus.img_w_blk = 0;
        bus.pix_valid = 0; bus.pix_idx = 0;
        bus.r = 0; bus.g = 0; bus.b = 0; bus.a = 0;
        bus.row_ready = 1'b1;
        repeat (2) @(posedge sclk);
        #1;
        check("rst_rtr", 128'(bus.pix_rtr), 128'(0));
        check("rst_valid", 128'(bus.row_valid), 128'(0));
        check("rst_done", 128'(bus.blk_done), 128'(0));
        check("rst_data", bus.row_data, 128'(0));
        check("rst_addr", 128'(bus.row_addr), 128'(0));
        rsrt = 1'b1;
        @(posedge sclk); #1;

        // Ordered fill with known address sequence.
        start_tile(2, 1, 8);
        for (int i = 0; i < 16; i++) begin
            send_pix(i, 8'(i));
            ma[i] = 8'h40;
        end
        push_rows();
        check("t1_rtr_drop", 128'(bus.pix_rtr), 128'(0));
        check("t1_addr0", 128'(bus.row_addr), 128'(136));
        check("t1_r_row0", 128'({bus.row_data[103:96], bus.row_data[71:64],
                                 bus.row_data[39:32], bus.row_data[7:0]}),
              128'(32'h0C080400));
        wait_done(1);

        // Backpressure on row 1.
        start_tile(5, 3, 20);
        for (int i = 0; i < 16; i++) send_pix(i, 8'($urandom));
        push_rows();
        @(posedge sclk); #1;
        bus.row_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge sclk); #1;
            check("bp_valid", 128'(bus.row_valid), 128'(1));
        end
        check("bp_addr_row1", 128'(bus.row_addr), 128'(24'((13)*80 + 20)));
        bus.row_ready = 1'b1;
        wait_done(2);

        // Duplicate index 5, remaining indices reversed.
        start_tile(0, 0, 4);
        send_pix(5, 8'h11);
        send_pix(5, 8'hAA);
        for (int i = 15; i >= 0; i--) begin
            if (i == 5) continue;
            if (i == 0) check("dup_not_done", 128'(bus.row_valid), 128'(0));
            send_pix(i, 8'($urandom));
        end
        push_rows();
        @(posedge sclk); #1;
        check("dup_slot_x1y1", 128'(bus.row_data[39:32]), 128'(8'hAA));
        wait_done(3);

        // blk_start in COLLECT and pix_valid in EMIT are ignored.
        start_tile(7, 2, 16);
        for (int i = 0; i < 8; i++) send_pix(i, 8'($urandom));
        bus.blk_start = 1'b1;
        bus.blk_x = 10'd99; bus.blk_y = 10'd77; bus.img_w_blk = 10'd3;
        send_pix(8, 8'($urandom));
        bus.blk_start = 1'b0;
        for (int i = 9; i < 16; i++) send_pix(i, 8'($urandom));
        push_rows();
        bus.row_ready = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_idx = 4'd0; bus.r = 8'hEE; bus.g = 8'hEE; bus.b = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(posedge sclk); #1;
            check("emit_rtr", 128'(bus.pix_rtr), 128'(0));
        end
        bus.pix_valid = 1'b0;
        bus.row_ready = 1'b1;
        wait_done(4);

        // blk_start coinciding with row-3 transfer is ignored.
        start_tile(1, 1, 4);
        for (int i = 0; i < 16; i++) send_pix(i, 8'($urandom));
        push_rows();
        repeat (3) @(posedge sclk);
        #1;
        check("co_row3_valid", 128'(bus.row_valid), 128'(1));
        bus.blk_start = 1'b1;
        @(posedge sclk); #1;
        bus.blk_start = 1'b0;
        check("co_start_ign", 128'(bus.pix_rtr), 128'(0));
        @(posedge sclk); #1;
        check("co_still_idle", 128'(bus.pix_rtr), 128'(0));
        wait_done(5);

        // Reset after 7 pixels discards the tile.
        start_tile(3, 0, 10);
        for (int i = 0; i < 7; i++) send_pix(i, 8'($urandom));
        rsrt = 1'b0;
        #1;
        check("mrst_rtr", 128'(bus.pix_rtr), 128'(0));
        check("mrst_valid", 128'(bus.row_valid), 128'(0));
        check("mrst_done", 128'(bus.blk_done), 128'(0));
        check("mrst_data", bus.row_data, 128'(0));
        check("mrst_addr", 128'(bus.row_addr), 128'(0));
        @(posedge sclk); #1;
        rsrt = 1'b1;
        repeat (3) @(posedge sclk);
        #1;
        check("mrst_no_done", 128'(done_cnt), 128'(5));
        check("mrst_idle", 128'(bus.pix_rtr), 128'(0));
        start_tile(4, 4, 12);
        for (int i = 15; i >= 0; i--) send_pix(i, 8'($urandom));
        push_rows();
        wait_done(6);
        repeat (3) @(posedge sclk);
        #1;
        check("final_done_cnt", 128'(done_cnt), 128'(6));
        check("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/etc_tile_writer.md
ETC_TILE_WRITER -- requirements
Module: etc_tile_writer

Interface
REQ-001 sclk  input  1  single clock; all state updates on its rising edge.
REQ-002 rsrt  input  1  reset, asynchronous assert, active-low.
REQ-003 blk_start  input  1  one-cycle pulse; latches blk_x, blk_y, img_w_blk and opens a new 4x4 tile.
REQ-004 blk_x  input  10  tile column, in blocks.
REQ-005 blk_y  input  10  tile row, in blocks.
REQ-006 img_w_blk  input  10  image width, in blocks.
REQ-007 pix_valid  input  1  decoded pixel valid; driven by the decoder's color_rts.
REQ-008 pix_idx  input  4  ETC pixel index, column-major: x = idx[3:2], y = idx[1:0].
REQ-009 r, g, b, a  input  8 each  decoded RGBA8888 pixel.
REQ-010 pix_rtr  output  1  ready for a pixel; drives the decoder's rtr.
REQ-011 row_valid  output  1  a raster row of 4 pixels is presented.
REQ-012 row_ready  input  1  downstream accepts the row.
REQ-013 row_data  output  128  pixel x occupies bits [32x+31:32x], packed {a,b,g,r} with r at the LSB.
REQ-014 row_addr  output  24  linear pixel address of the row's first pixel.
REQ-015 blk_done  output  1  one-cycle pulse after the last row transfers.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, COLLECT and EMIT.
REQ-017 In IDLE, blk_start SHALL latch the tile parameters, clear the 16-bit fill mask and move the FSM to COLLECT on the next cycle.
REQ-018 pix_rtr SHALL equal (state==COLLECT), decoded from the state register only.
REQ-019 In COLLECT, pix_valid SHALL write the pixel to slot (row y, column x) and set mask[pix_idx].
REQ-020 A repeated index SHALL overwrite that slot and SHALL NOT advance completion.
REQ-021 When the mask becomes all-ones, the FSM SHALL enter EMIT on the next edge, so pix_rtr drops one cycle after the last accept.
REQ-022 row_valid SHALL assert in the first EMIT cycle with row counter 0.
REQ-023 row_data and row_addr SHALL hold stable while row_valid=1 and row_ready=0.
REQ-024 A row SHALL transfer on row_valid & row_ready and the row counter SHALL then increment.
REQ-025 row_addr SHALL equal ((blk_y*4 + row) * img_w_blk*4) + blk_x*4, truncated to 24 bits.
REQ-026 On transfer of row 3, blk_done SHALL pulse for exactly one cycle, row_valid SHALL deassert and the FSM SHALL return to IDLE.
REQ-027 blk_start in COLLECT or EMIT SHALL be ignored.
REQ-028 pix_valid in IDLE or EMIT SHALL be ignored and leave storage and mask unchanged.
REQ-029 If blk_start and row-3 transfer coincide, blk_start SHALL be ignored; a new tile requires blk_start while in IDLE.
REQ-030 Minimum tile time SHALL be 1 + 16 + 4 cycles with continuous valid/ready.

Reset
REQ-031 rsrt=0 SHALL immediately force IDLE and drive pix_rtr=0, row_valid=0, blk_done=0, row_data=0 and row_addr=0.
REQ-032 rsrt=0 SHALL clear the mask, row counter and latched parameters; pixel storage need not clear.
REQ-033 Reset mid-COLLECT or mid-EMIT SHALL discard the tile; no blk_done SHALL follow.

Configuration
REQ-034 With ETC_TILE_WRITER_ALPHA_EN defined, input a SHALL be stored and emitted.
REQ-035 Without ETC_TILE_WRITER_ALPHA_EN, the alpha byte SHALL be emitted as 8'hFF, no alpha storage SHALL be built and input a SHALL be unused.

Verification
REQ-036 Ordered fill: blk_x=2, blk_y=1, img_w_blk=8; pixels idx 0..15 with r=idx -> row0 r-bytes 0,4,8,12; row_addr 136, 168, 200, 232; blk_done after row 3.
REQ-037 Backpressure: row_ready=0 for 5 cycles on row 1 -> row_data and row_addr constant; no row skipped; blk_done once.
REQ-038 Duplicates and out-of-order: idx 5 sent twice (second with r=8'hAA), remaining indices reversed -> EMIT only after all 16 indices seen; slot (x1,y1) = 8'hAA.
REQ-039 Ignored inputs: blk_start during COLLECT and pix_valid during EMIT -> parameters, mask and data unchanged; pix_rtr=0 throughout EMIT.
REQ-040 Reset: rsrt low after 7 pixels -> all outputs 0 at once; new tile after release completes normally with its own values.
REQ-041 Alpha: a=8'h40 with the macro defined -> top byte 8'h40; without the macro -> 8'hFF.
